// File: rtl/fu_issue_scheduler_pkg.sv
// Shared definitions for the FU issue scheduler: unit counts, FU class
// encoding, MEM FSM states and the packed per-class empty vector.
package fu_issue_scheduler_pkg;

    localparam int NUM_ALU  = 3;
    localparam int NUM_MULT = 2;
    localparam int MULT_LAT = 4;
    localparam int ISSUE_W  = 3;

    typedef enum logic [1:0] {
        FUNC_NOP = 2'd0,
        FUNC_ALU = 2'd1,
        FUNC_MUL = 2'd2,
        FUNC_MEM = 2'd3
    } fu_class_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [NUM_ALU-1:0]  alu_empty;
        logic [NUM_MULT-1:0] mult_empty;
        logic                mem_empty;
    } fu_empty_packet_t;

endpackage

// File: rtl/fu_issue_scheduler_mult_tracker.sv
// Occupancy tracker for one non-pipelined multiplier: busy bit, latency
// countdown and a one-cycle done pulse when the result becomes valid.
module fu_mult_tracker #(
    parameter int MULT_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic squash,
    input  logic i_start,
    input  logic i_ack,
    output logic o_empty,
    output logic o_done
);

    localparam int CNT_W = $clog2(MULT_LAT) + 1;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset || squash) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_busy && (r_cnt == CNT_W'(1));
            if (r_busy && (r_cnt == '0) && i_ack) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= CNT_W'(MULT_LAT - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // A pulse already registered is still masked in the squash cycle itself.
    assign o_done  = r_done && !squash;
    assign o_empty = !r_busy;

endmodule

// File: rtl/fu_issue_scheduler.sv
// Routes up to ISSUE_W issued packets per cycle onto free ALU/MULT/MEM units
// and tracks per-unit occupancy for the reservation station's ready masking.
module fu_issue_scheduler
    import fu_issue_scheduler_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic [ISSUE_W-1:0]    is_valid,
    input  logic [2*ISSUE_W-1:0]  is_func,
    input  logic [NUM_ALU-1:0]    alu_ack,
    input  logic [NUM_MULT-1:0]   mult_ack,
    input  logic                  mem_done,
    output logic [ISSUE_W-1:0]    grant,
    output logic [ISSUE_W-1:0]    reject,
    output logic [2*ISSUE_W-1:0]  unit_sel,
    output logic [NUM_ALU-1:0]    alu_empty,
    output logic [NUM_MULT-1:0]   mult_empty,
    output logic                  mem_empty,
    output logic [NUM_MULT-1:0]   mult_done
);

    logic [NUM_ALU-1:0]  r_alu_empty;
    mem_state_t          r_mem_state;
    logic                r_mem_empty;
    logic [NUM_MULT-1:0] w_mult_empty;
    fu_empty_packet_t    w_empty;

    logic [NUM_ALU-1:0]  w_alu_avail;
    logic [NUM_MULT-1:0] w_mult_avail;
    logic                w_mem_avail;
    logic [NUM_ALU-1:0]  w_alu_start;
    logic [NUM_MULT-1:0] w_mult_start;
    logic                w_mem_start;
    logic                w_found;
    fu_class_t           w_class;

    assign w_empty    = '{alu_empty: r_alu_empty, mult_empty: w_mult_empty, mem_empty: r_mem_empty};
    assign alu_empty  = w_empty.alu_empty;
    assign mult_empty = w_empty.mult_empty;
    assign mem_empty  = w_empty.mem_empty;

    // Per-class priority selector: lower slots claim units first, and only
    // registered empty bits count as free (a same-cycle ack frees nothing).
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_alu_avail  = w_empty.alu_empty;
        w_mult_avail = w_empty.mult_empty;
        w_mem_avail  = w_empty.mem_empty;
        w_alu_start  = '0;
        w_mult_start = '0;
        w_mem_start  = 1'b0;
        w_found      = 1'b0;
        w_class      = FUNC_NOP;
        grant        = '0;
        reject       = '0;
        unit_sel     = '0;
        for (int s = 0; s < ISSUE_W; s++) begin
            w_found = 1'b0;
            w_class = is_valid[s] ? fu_class_t'(is_func[2*s +: 2]) : FUNC_NOP;
            case (w_class)
                FUNC_ALU: begin
                    for (int u = 0; u < NUM_ALU; u++) begin
                        if (!w_found && w_alu_avail[u]) begin
                            w_found            = 1'b1;
                            w_alu_avail[u]     = 1'b0;
                            w_alu_start[u]     = 1'b1;
                            unit_sel[2*s +: 2] = 2'(u);
                        end
                    end
                end
                FUNC_MUL: begin
                    for (int u = 0; u < NUM_MULT; u++) begin
                        if (!w_found && w_mult_avail[u]) begin
                            w_found            = 1'b1;
                            w_mult_avail[u]    = 1'b0;
                            w_mult_start[u]    = 1'b1;
                            unit_sel[2*s +: 2] = 2'(u);
                        end
                    end
                end
                FUNC_MEM: begin
                    if (w_mem_avail) begin
                        w_found     = 1'b1;
                        w_mem_avail = 1'b0;
                        w_mem_start = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_class != FUNC_NOP) begin
                grant[s]  = w_found;
                reject[s] = !w_found;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || squash) begin
            r_alu_empty <= '1;
        end else begin
            for (int k = 0; k < NUM_ALU; k++) begin
                if (alu_ack[k]) begin
                    r_alu_empty[k] <= 1'b1;
                end else if (w_alu_start[k]) begin
                    r_alu_empty[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || squash) begin
            r_mem_state <= MEM_IDLE;
            r_mem_empty <= 1'b1;
        end else begin
            case (r_mem_state)
                MEM_IDLE: begin
                    if (w_mem_start) begin
                        r_mem_state <= MEM_BUSY;
                        r_mem_empty <= 1'b0;
                    end
                end
                MEM_BUSY: begin
                    if (mem_done) begin
                        r_mem_state <= MEM_IDLE;
                        r_mem_empty <= 1'b1;
                    end
                end
                default: begin
                    r_mem_state <= MEM_IDLE;
                    r_mem_empty <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_MULT; g++) begin : g_mult
        fu_mult_tracker #(
            .MULT_LAT(MULT_LAT)
        ) u_mult (
            .clock   (clock),
            .reset   (reset),
            .squash  (squash),
            .i_start (w_mult_start[g]),
            .i_ack   (mult_ack[g]),
            .o_empty (w_mult_empty[g]),
            .o_done  (mult_done[g])
        );
    end

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler: routing, occupancy, multiplier
// latency, overflow rejection, squash and mid-operation reset.
module tb_fu_issue_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       squash;
    logic [2:0] is_valid;
    logic [5:0] is_func;
    logic [2:0] alu_ack;
    logic [1:0] mult_ack;
    logic       mem_done;
    logic [2:0] grant;
    logic [2:0] reject;
    logic [5:0] unit_sel;
    logic [2:0] alu_empty;
    logic [1:0] mult_empty;
    logic       mem_empty;
    logic [1:0] mult_done;

    int n_checks = 0;
    int n_errors = 0;

    fu_issue_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .is_valid   (is_valid),
        .is_func    (is_func),
        .alu_ack    (alu_ack),
        .mult_ack   (mult_ack),
        .mem_done   (mem_done),
        .grant      (grant),
        .reject     (reject),
        .unit_sel   (unit_sel),
        .alu_empty  (alu_empty),
        .mult_empty (mult_empty),
        .mem_empty  (mem_empty),
        .mult_done  (mult_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then driven 2 time units after it.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        squash   = 1'b0;
        is_valid = 3'b000;
        is_func  = 6'b0;
        alu_ack  = 3'b000;
        mult_ack = 2'b00;
        mem_done = 1'b0;
    endtask

    task automatic check_all_empty(input string tag);
        check({tag, "_alu"},  32'(alu_empty),  32'h7);
        check({tag, "_mult"}, 32'(mult_empty), 32'h3);
        check({tag, "_mem"},  32'(mem_empty),  32'h1);
        check({tag, "_done"}, 32'(mult_done),  32'h0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check_all_empty("reset");
        check("reset_grant",  32'(grant),  32'h0);
        check("reset_reject", 32'(reject), 32'h0);

        // Three ALU slots: units 0,1,2 in slot order.
        is_valid = 3'b111;
        is_func  = 6'b01_01_01;
        #1;
        check("alu3_grant",  32'(grant),    32'h7);
        check("alu3_reject", 32'(reject),   32'h0);
        check("alu3_sel",    32'(unit_sel), 32'(6'b10_01_00));
        step();
        idle_inputs();
        alu_ack = 3'b010;
        #1;
        check("alu3_busy", 32'(alu_empty), 32'h0);
        step();
        idle_inputs();
        #1;
        check("alu_ack1", 32'(alu_empty), 32'h2);
        alu_ack = 3'b101;
        step();
        idle_inputs();
        #1;
        check("alu_ack_all", 32'(alu_empty), 32'h7);

        // MULT in slot 1 at cycle t; done pulse visible at t+4.
        is_valid = 3'b010;
        is_func  = 6'b00_10_00;
        #1;
        check("mul_grant", 32'(grant),    32'h2);
        check("mul_sel",   32'(unit_sel), 32'h0);
        step();
        idle_inputs();
        #1;
        check("mul_t1_empty", 32'(mult_empty), 32'h2);
        check("mul_t1_done",  32'(mult_done),  32'h0);
        step();
        mult_ack = 2'b01;
        #1;
        check("mul_t2_done", 32'(mult_done), 32'h0);
        step();
        idle_inputs();
        #1;
        check("mul_early_ack_ignored", 32'(mult_empty), 32'h2);
        check("mul_t3_done", 32'(mult_done), 32'h0);
        step();
        #1;
        check("mul_t4_done",  32'(mult_done),  32'h1);
        check("mul_t4_empty", 32'(mult_empty), 32'h2);
        step();
        #1;
        check("mul_t5_done",  32'(mult_done),  32'h0);
        check("mul_t5_empty", 32'(mult_empty), 32'h2);
        mult_ack = 2'b01;
        step();
        idle_inputs();
        #1;
        check("mul_acked", 32'(mult_empty), 32'h3);

        // Occupy both MULTs, then overflow with {MULT, MEM, MULT}.
        is_valid = 3'b011;
        is_func  = 6'b00_10_10;
        #1;
        check("mul2_grant", 32'(grant),    32'h3);
        check("mul2_sel",   32'(unit_sel), 32'(6'b00_01_00));
        step();
        is_valid = 3'b111;
        is_func  = 6'b10_11_10;
        #1;
        check("ovf_grant",  32'(grant),    32'h2);
        check("ovf_reject", 32'(reject),   32'h5);
        check("ovf_sel",    32'(unit_sel), 32'h0);
        step();
        idle_inputs();
        #1;
        check("ovf_mem_busy",  32'(mem_empty),  32'h0);
        check("ovf_mult_busy", 32'(mult_empty), 32'h0);

        // Squash with MULT cnt=2, MEM busy and a simultaneous ALU grant.
        squash   = 1'b1;
        is_valid = 3'b001;
        is_func  = 6'b00_00_01;
        #1;
        check("sq_alu_grant", 32'(grant), 32'h1);
        step();
        idle_inputs();
        #1;
        check_all_empty("squash");
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            check("sq_no_done", 32'(mult_done), 32'h0);
        end

        // MEM round trip, and mem_done while idle.
        is_valid = 3'b001;
        is_func  = 6'b00_00_11;
        #1;
        check("mem_grant", 32'(grant), 32'h1);
        step();
        idle_inputs();
        #1;
        check("mem_busy", 32'(mem_empty), 32'h0);
        mem_done = 1'b1;
        step();
        idle_inputs();
        #1;
        check("mem_freed", 32'(mem_empty), 32'h1);
        mem_done = 1'b1;
        step();
        idle_inputs();
        #1;
        check("mem_done_idle", 32'(mem_empty), 32'h1);

        // Ack in the same cycle as the done pulse frees the unit next cycle.
        is_valid = 3'b001;
        is_func  = 6'b00_00_10;
        step();
        idle_inputs();
        step();
        step();
        step();
        #1;
        check("mul_ackdone_pulse", 32'(mult_done), 32'h1);
        mult_ack = 2'b01;
        step();
        idle_inputs();
        #1;
        check("mul_ackdone_empty", 32'(mult_empty), 32'h3);
        check("mul_ackdone_nodone", 32'(mult_done), 32'h0);

        // Squash masks a pulse already due in the squash cycle.
        is_valid = 3'b001;
        is_func  = 6'b00_00_10;
        step();
        idle_inputs();
        step();
        step();
        step();
        squash = 1'b1;
        #1;
        check("sq_cycle_mask", 32'(mult_done), 32'h0);
        step();
        idle_inputs();
        #1;
        check_all_empty("sq_cycle");

        // Reset mid-operation with valid slots present.
        is_valid = 3'b111;
        is_func  = 6'b11_10_01;
        step();
        is_valid = 3'b111;
        is_func  = 6'b11_10_01;
        #1;
        check("rst_pre_grant", 32'(grant),  32'h3);
        check("rst_pre_reject", 32'(reject), 32'h4);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle_inputs();
        #1;
        check_all_empty("midreset");
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            check("midreset_no_done", 32'(mult_done), 32'h0);
        end
        check_all_empty("midreset_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
